program_loader: RTL and testbench

- Boot-time loader that writes a program image into the processor's 256 x 17-bit instruction/data memory.
- Receives a byte stream over a valid/ready handshake and packs it into 17-bit words.
- Writes each word through the memory write port (WE/ad/data), starting at address 0.
- Holds the processor in reset while loading, and releases it only after a verified load.

---
 rtl/loader_pkg.sv | 36 +++
 rtl/word_packer.sv | 54 +++++
 rtl/program_loader.sv | 183 ++++++++++++++++++
 tb/tb_program_loader.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, stream
// framing constants, default memory geometry and the checksum helper.
package loader_pkg;

    localparam int BYTES_PER_WORD = 3;
    localparam int W_DEF          = 17;
    localparam int AW_DEF         = 8;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        COUNT = 4'd1,
        B0    = 4'd2,
        B1    = 4'd3,
        B2    = 4'd4,
        WRITE = 4'd5,
        CHK   = 4'd6,
        DONE  = 4'd7,
        FAIL  = 4'd8
    } state_t;

    // Running checksum is a plain byte-wise XOR.
    function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] data);
        return chk ^ data;
    endfunction

    // States in which the loader takes a byte from the stream.
    function automatic logic accepts_byte(input state_t s);
        return (s == COUNT) || (s == B0) || (s == B1) || (s == B2) || (s == CHK);
    endfunction

    // States that make up an active load.
    function automatic logic is_busy(input state_t s);
        return accepts_byte(s) || (s == WRITE);
    endfunction

endpackage

// File: rtl/word_packer.sv
// Byte-lane register that assembles one 17-bit memory word from three stream
// bytes (LSB first) and keeps the running XOR checksum of the stream.
// Ports:
//   clk, reset     - clock and async active-low reset
//   chk_init       - seed the checksum with byte_in (count byte)
//   lane_load[2:0] - one-hot: latch byte_in into lane 0/1/2 and fold it into chk
//   byte_in        - stream byte
//   word           - assembled word {b2[0], b1, b0}
//   chk            - running checksum
module word_packer
    import loader_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         chk_init,
    input  logic [2:0]   lane_load,
    input  logic [7:0]   byte_in,
    output logic [W-1:0] word,
    output logic [7:0]   chk
);

    logic [7:0] b0_r;
    logic [7:0] b1_r;
    logic       b2_r;
    logic [7:0] chk_r;

    // Byte lanes and checksum register; only bit 0 of the third byte is kept,
    // although the whole byte enters the checksum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            b0_r  <= 8'h00;
            b1_r  <= 8'h00;
            b2_r  <= 1'b0;
            chk_r <= 8'h00;
        end else begin
            if (chk_init) begin
                chk_r <= byte_in;
            end else if (lane_load != 3'b000) begin
                chk_r <= chk_update(chk_r, byte_in);
            end else begin
                chk_r <= chk_r;
            end
            if (lane_load[0]) b0_r <= byte_in;
            if (lane_load[1]) b1_r <= byte_in;
            if (lane_load[2]) b2_r <= byte_in[0];
        end
    end

    assign word = {b2_r, b1_r, b0_r};
    assign chk  = chk_r;

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader. Accepts a byte stream (count, N x 3-byte words,
// optional XOR checksum), writes each word into the processor memory from
// address 0 and holds the processor in reset until a verified load completes.
// Ports:
//   clk, reset (async active-low), start (one-cycle pulse)
//   in_data/in_valid/in_ready - byte stream handshake
//   mem_we/mem_ad/mem_data    - memory write port, one mem_we cycle per word
//   cpu_hold                  - 1 keeps the processor in reset
//   busy/done/err             - load status; done and err are sticky
module program_loader
    import loader_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int AW    = AW_DEF,
    parameter int CHECK = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_ad,
    output logic [W-1:0]  mem_data,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_t        state_r;
    state_t        next_state_s;
    logic          xfer_s;
    logic          chk_init_s;
    logic [2:0]    lane_load_s;
    logic [7:0]    chk_s;
    logic [AW:0]   rem_r;
    logic [AW-1:0] addr_r;
    logic          in_ready_r;
    logic          mem_we_r;
    logic          cpu_hold_r;
    logic          busy_r;
    logic          done_r;
    logic          err_r;

    assign xfer_s = in_valid & in_ready_r;

    word_packer #(.W(W)) u_packer (
        .clk       (clk),
        .reset     (reset),
        .chk_init  (chk_init_s),
        .lane_load (lane_load_s),
        .byte_in   (in_data),
        .word      (mem_data),
        .chk       (chk_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic and packer controls.
    always_comb begin
        next_state_s = state_r;
        chk_init_s   = 1'b0;
        lane_load_s  = 3'b000;
        case (state_r)
            IDLE, DONE, FAIL: begin
                if (start) next_state_s = COUNT;
                else       next_state_s = state_r;
            end
            COUNT: begin
                if (xfer_s) begin
                    chk_init_s   = 1'b1;
                    next_state_s = B0;
                end else begin
                    next_state_s = COUNT;
                end
            end
            B0: begin
                if (xfer_s) begin
                    lane_load_s  = 3'b001;
                    next_state_s = B1;
                end else begin
                    next_state_s = B0;
                end
            end
            B1: begin
                if (xfer_s) begin
                    lane_load_s  = 3'b010;
                    next_state_s = B2;
                end else begin
                    next_state_s = B1;
                end
            end
            B2: begin
                if (xfer_s) begin
                    lane_load_s  = 3'b100;
                    next_state_s = WRITE;
                end else begin
                    next_state_s = B2;
                end
            end
            WRITE: begin
                if (rem_r == (AW+1)'(1)) begin
                    if (CHECK != 0) next_state_s = CHK;
                    else            next_state_s = DONE;
                end else begin
                    next_state_s = B0;
                end
            end
            CHK: begin
                if (xfer_s) begin
                    if (in_data == chk_s) next_state_s = DONE;
                    else                  next_state_s = FAIL;
                end else begin
                    next_state_s = CHK;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Word counter and write address; a count byte of 0 stands for 2**AW words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_r  <= '0;
            addr_r <= '0;
        end else begin
            case (state_r)
                COUNT: begin
                    if (xfer_s) begin
                        rem_r  <= (in_data == 8'h00) ? {1'b1, {AW{1'b0}}} : (AW+1)'(in_data);
                        addr_r <= '0;
                    end
                end
                WRITE: begin
                    rem_r  <= rem_r - (AW+1)'(1);
                    addr_r <= addr_r + AW'(1);
                end
                default: begin
                    rem_r  <= rem_r;
                    addr_r <= addr_r;
                end
            endcase
        end
    end

    // Status and handshake outputs registered from the upcoming state so they
    // line up exactly with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready_r <= 1'b0;
            mem_we_r   <= 1'b0;
            cpu_hold_r <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            in_ready_r <= accepts_byte(next_state_s);
            mem_we_r   <= (next_state_s == WRITE);
            cpu_hold_r <= (next_state_s != DONE);
            busy_r     <= is_busy(next_state_s);
            done_r     <= (next_state_s == DONE);
            err_r      <= (next_state_s == FAIL);
        end
    end

    assign in_ready = in_ready_r;
    assign mem_we   = mem_we_r;
    assign mem_ad   = addr_r;
    assign cpu_hold = cpu_hold_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a scoreboard queue of expected
// memory writes is filled as stream bytes are driven and drained by a monitor
// whenever mem_we is seen.
module tb_program_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_ad;
    logic [16:0] mem_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct {
        logic [7:0]  ad;
        logic [16:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          checks;
    int          errors;
    logic [23:0] words [256];
    logic [7:0]  last_ad;
    logic [16:0] last_data;
    int          write_count;

    program_loader #(.W(17), .AW(8), .CHECK(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_ad   (mem_ad),
        .mem_data (mem_data),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: every mem_we cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset === 1'b1 && mem_we === 1'b1) begin
            wr_t e;
            write_count++;
            last_ad   = mem_ad;
            last_data = mem_data;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: ad=%h data=%h, no write expected", mem_ad, mem_data);
            end else begin
                e = exp_q.pop_front();
                if (mem_ad !== e.ad || mem_data !== e.data) begin
                    errors++;
                    $display("FAIL write: ad=%h data=%h, expected ad=%h data=%h", mem_ad, mem_data, e.ad, e.data);
                end
            end
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL ready_in_write: in_ready=%b, expected 0", in_ready);
            end
        end
    end

    // Present one byte and hold it until accepted; returns #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%b after 50 cycles, expected 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Drive a full image from words[]; bad flips the checksum; abort_word >= 0
    // stops right after that word's first byte.
    task automatic run_load(input int n, input bit bad, input bit stall, input int abort_word);
        logic [7:0] c;
        logic [7:0] b0, b1, b2;
        c = (n == 256) ? 8'h00 : 8'(n);
        send_byte(c);
        for (int k = 0; k < n; k++) begin
            b0 = words[k][7:0];
            b1 = words[k][15:8];
            b2 = words[k][23:16];
            if (stall) idle_cycles($urandom_range(0, 2));
            send_byte(b0);
            c = c ^ b0;
            if (k == abort_word) return;
            if (stall) idle_cycles($urandom_range(0, 2));
            send_byte(b1);
            c = c ^ b1;
            if (stall) idle_cycles($urandom_range(0, 2));
            exp_q.push_back('{ad: 8'(k), data: {b2[0], b1, b0}});
            send_byte(b2);
            c = c ^ b2;
        end
        if (stall) idle_cycles($urandom_range(0, 2));
        send_byte(bad ? (c ^ 8'h01) : c);
        in_valid = 1'b0;
    endtask

    task automatic check_status(input string name, input logic e_done, input logic e_err,
                                input logic e_hold, input logic e_busy);
        checks++;
        if (done !== e_done || err !== e_err || cpu_hold !== e_hold || busy !== e_busy ||
            exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: done=%b err=%b cpu_hold=%b busy=%b pending=%0d, expected %b %b %b %b 0",
                     name, done, err, cpu_hold, busy, exp_q.size(), e_done, e_err, e_hold, e_busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        checks++;
        if (cpu_hold !== 1'b1 || mem_we !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 ||
            err !== 1'b0 || mem_ad !== 8'h00 || busy !== 1'b0 || mem_data !== 17'h0) begin
            errors++;
            $display("FAIL reset: hold=%b we=%b rdy=%b done=%b err=%b ad=%h busy=%b data=%h, expected 1 0 0 0 0 00 0 00000",
                     cpu_hold, mem_we, in_ready, done, err, mem_ad, busy, mem_data);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        // IDLE must not take bytes
        in_valid = 1'b1;
        in_data  = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (in_ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_ready: in_ready=%b busy=%b, expected 0 0", in_ready, busy);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_good_load();
        words[0] = 24'h01ABCD;
        words[1] = 24'h000012;
        do_start();
        checks++;
        if (busy !== 1'b1 || cpu_hold !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL start: busy=%b hold=%b rdy=%b, expected 1 1 1", busy, cpu_hold, in_ready);
        end
        run_load(2, 1'b0, 1'b0, -1);
        check_status("good_load", 1'b1, 1'b0, 1'b0, 1'b0);
        // DONE ignores stream bytes and stays put
        in_valid = 1'b1;
        in_data  = 8'h33;
        idle_cycles(0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL done_hold: in_ready=%b done=%b, expected 0 1", in_ready, done);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_bad_checksum();
        words[0] = 24'h01ABCD;
        words[1] = 24'h000012;
        do_start();
        checks++;
        if (cpu_hold !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL restart_hold: cpu_hold=%b done=%b, expected 1 0", cpu_hold, done);
        end
        run_load(2, 1'b1, 1'b0, -1);
        check_status("bad_checksum", 1'b0, 1'b1, 1'b1, 1'b0);
        idle_cycles(2);
        check_status("fail_sticky", 1'b0, 1'b1, 1'b1, 1'b0);
        do_start();
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL err_clear: err=%b busy=%b, expected 0 1", err, busy);
        end
        // start while busy is ignored: the load still completes normally
        do_start();
        words[0] = 24'h00BEEF;
        run_load(1, 1'b0, 1'b0, -1);
        check_status("reload_after_fail", 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        for (int k = 0; k < 12; k++) words[k] = 24'($urandom());
        do_start();
        run_load(12, 1'b0, 1'b1, -1);
        check_status("stall", 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_full_image();
        int wc;
        for (int k = 0; k < 256; k++) words[k] = 24'(k * 3);
        wc = write_count;
        do_start();
        run_load(256, 1'b0, 1'b0, -1);
        check_status("full_image", 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (write_count - wc != 256 || last_ad !== 8'hFF || last_data !== 17'h002FD) begin
            errors++;
            $display("FAIL full_last: writes=%0d ad=%h data=%h, expected 256 ff 002fd",
                     write_count - wc, last_ad, last_data);
        end
    endtask

    task automatic test_reset_mid_load();
        int wc;
        for (int k = 0; k < 8; k++) words[k] = 24'(32'h10000 + k * 17);
        wc = write_count;
        do_start();
        run_load(8, 1'b0, 1'b0, 4);
        in_valid = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (cpu_hold !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || mem_we !== 1'b0 ||
            mem_ad !== 8'h00 || write_count - wc != 4) begin
            errors++;
            $display("FAIL mid_reset: hold=%b busy=%b rdy=%b we=%b ad=%h writes=%0d, expected 1 0 0 0 00 4",
                     cpu_hold, busy, in_ready, mem_we, mem_ad, write_count - wc);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_status("after_mid_reset", 1'b0, 1'b0, 1'b1, 1'b0);
        words[0] = 24'h015555;
        words[1] = 24'h00AAAA;
        words[2] = 24'hFE0001;
        do_start();
        run_load(3, 1'b0, 1'b1, -1);
        check_status("reload", 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        write_count = 0;
        last_ad     = 8'h00;
        last_data   = 17'h0;
        reset       = 1'b0;
        start       = 1'b0;
        in_data     = 8'h00;
        in_valid    = 1'b0;
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_stall();
        test_full_image();
        test_reset_mid_load();
        idle_cycles(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
